booth_mul_seq: RTL and testbench

//   Iterative radix-4 modified-Booth multiplier, parametrised in operand width.

---
 rtl/booth_mul_pkg.sv | 24 ++
 rtl/booth_digit_enc.sv | 20 ++
 rtl/booth_mul_seq.sv | 158 +++++++++++++++
 tb/tb_booth_mul_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
//   state_t     : engine FSM states (IDLE, CALC, DONE)
//   booth_dig_t : one encoded Booth digit (neg, one, two)
//   ceil_even() : rounds an operand width up to the next even value
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit value = (neg ? -1 : +1) * (two ? 2 : (one ? 1 : 0))
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_dig_t;

    function automatic int ceil_even(input int w);
        return ((w + 1) / 2) * 2;
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 modified-Booth digit encoder (purely combinational).
// Ports:
//   q   in  3  overlapping multiplier bits {q2, q1, q0}
//   dig out    encoded digit in {-2,-1,0,+1,+2} as {neg, one, two}
module booth_digit_enc
    import booth_mul_pkg::*;
(
    input  logic [2:0] q,
    output booth_dig_t dig
);

    always_comb begin
        dig.one = q[1] ^ q[0];
        // Magnitude 2 only for 011 / 100, i.e. q1==q0 while q2!=q1
        dig.two = ~(dig.one | (q[2] ~^ q[1]));
        // 111 yields neg with zero magnitude, which the datapath handles as 0
        dig.neg = q[2];
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 modified-Booth multiplier, one Booth digit per clock.
// Signed or unsigned operands, selected per transaction by is_signed.
// Optional feature: define BOOTH_MUL_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits can only produce zero digits (variable latency).
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    operands valid
//   in_ready   out  1    engine idle, operands accepted when in_valid
//   a          in   W    multiplicand
//   b          in   W    multiplier
//   is_signed  in   1    1: two's-complement operands, 0: unsigned
//   out_valid  out  1    product valid, held until out_ready
//   out_ready  in   1    consumer accepts product
//   product    out  2W   exact a*b for the selected mode
//   busy       out  1    engine not idle
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int ND    = ceil_even(W) / 2 + 1;
    localparam int CNT_W = $clog2(ND + 1);
    localparam int MW    = W + 2;       // multiplicand / partial-sum width
    localparam int QW    = W + 3;       // multiplier plus the Booth guard bit
    localparam int AW    = 2 * W + 2;   // accumulator width

    state_t                state, state_next;
    logic signed [MW-1:0]  mcand, mcand_next;
    logic signed [QW-1:0]  mplier, mplier_next, mplier_shift;
    logic signed [AW-1:0]  acc, acc_next, acc_add;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic signed [MW-1:0]  pp, sum;
    booth_dig_t            dig;
    logic                  ext;
    logic                  last_dig;

    booth_digit_enc u_enc (
        .q   (mplier[2:0]),
        .dig (dig)
    );

    // Partial product and accumulate: d*M is added into the upper W+2 bits.
    always_comb begin
        pp = '0;
        if (dig.two) begin
            pp = mcand <<< 1;
        end else if (dig.one) begin
            pp = mcand;
        end
        // Negative digits: ones' complement here, +1 enters as the carry-in
        if (dig.neg) begin
            pp = ~pp;
        end
        sum          = acc[AW-1:W] + pp + MW'(dig.neg);
        acc_add      = {sum, acc[W-1:0]};
        mplier_shift = mplier >>> 2;
    end

    // The final digit is added without a shift so that digit i lands at
    // weight 4^i and the product sits at acc[2W-1:0] with no fraction lost.
    assign last_dig = (cnt == CNT_W'(ND - 1));

`ifdef BOOTH_MUL_EARLY_TERM_EN
    localparam int SH_W = $clog2(AW);
    logic            early;
    logic [SH_W-1:0] rem_sh;

    // All-zero or all-one remaining bits encode only zero digits, so the
    // outstanding shifts can be applied in one step.
    always_comb begin
        early  = (&mplier_shift) | (~|mplier_shift);
        rem_sh = SH_W'(2 * (ND - 1 - int'(cnt)));
    end
`endif

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        acc_next    = acc;
        cnt_next    = cnt;
        ext         = is_signed & b[W-1];
        case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_next  = is_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
                    mplier_next = {ext, ext, b, 1'b0};
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = CALC;
                end
            end
            CALC: begin
                mplier_next = mplier_shift;
                cnt_next    = cnt + CNT_W'(1);
                if (last_dig) begin
                    acc_next   = acc_add;
                    state_next = DONE;
                end
`ifdef BOOTH_MUL_EARLY_TERM_EN
                else if (early) begin
                    acc_next   = acc_add >>> rem_sh;
                    state_next = DONE;
                end
`endif
                else begin
                    acc_next = acc_add >>> 2;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // acc is reset as well so that product reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        mcand  <= mcand_next;
        mplier <= mplier_next;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = acc[2*W-1:0];

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        in_valid16, in_ready16, is_signed16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    booth_mul_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    booth_mul_seq #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .is_signed(is_signed16), .out_valid(out_valid16),
        .out_ready(out_ready16), .product(product16), .busy(busy16)
    );

`ifdef BOOTH_MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    typedef struct {
        longint prod;
        int     lat;
        int     acc_cyc;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   bp_en      = 1'b0;
    logic pv8        = 1'b0;
    logic pv16       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain integer arithmetic on the interpreted operands.
    function automatic longint ext_val(input longint v, input int w, input bit s);
        longint r;
        r = v & ((longint'(1) <<< w) - 1);
        if (s && r[w-1]) r = r - (longint'(1) <<< w);
        return r;
    endfunction

    function automatic longint ref_prod(input longint x, input longint y, input int w, input bit s);
        longint p;
        p = ext_val(x, w, s) * ext_val(y, w, s);
        return p & ((longint'(1) <<< (2 * w)) - 1);
    endfunction

    // With early termination the run stops after the first digit k whose
    // remaining multiplier value (2*b / 4^k, floored) is 0 or -1.
    function automatic int ref_lat(input longint y, input int w, input bit s);
        int     nd;
        int     k0;
        longint q;
        nd = w / 2 + 1;
        k0 = nd;
        q  = 2 * ext_val(y, w, s);
        for (int k = nd - 1; k >= 1; k--) begin
            if ((q >>> (2 * k)) == 0 || (q >>> (2 * k)) == -1) k0 = k;
        end
        return ET ? k0 : nd;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Monitors: latency checked on the rising out_valid, product on every
    // valid cycle (covers hold stability), pop on handshake.
    always @(negedge clk) begin
        if (out_valid8) begin
            if (sb8.size() == 0) begin
                fail_now("unexpected_out8");
            end else begin
                if (!pv8) chk("latency8", cyc - sb8[0].acc_cyc, sb8[0].lat);
                chk("product8", product8, sb8[0].prod);
                if (out_ready8) void'(sb8.pop_front());
            end
        end
        pv8 <= out_valid8;
    end

    always @(negedge clk) begin
        if (out_valid16) begin
            if (sb16.size() == 0) begin
                fail_now("unexpected_out16");
            end else begin
                if (!pv16) chk("latency16", cyc - sb16[0].acc_cyc, sb16[0].lat);
                chk("product16", product16, sb16[0].prod);
                if (out_ready16) void'(sb16.pop_front());
            end
        end
        pv16 <= out_valid16;
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_ready8 = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input bit track);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = ta; b8 = tb; is_signed8 = ts;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready8 && n < 300);
        if (!in_ready8) begin
            fail_now("accept8");
            in_valid8 = 1'b0;
            return;
        end
        if (track) begin
            e.prod    = ref_prod(ta, tb, 8, ts);
            e.lat     = ref_lat(tb, 8, ts);
            e.acc_cyc = cyc + 1;
            sb8.push_back(e);
        end
        @(posedge clk); #1;
        // Operands and mode change after accept; the engine must ignore them.
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); is_signed8 = ~ts;
    endtask

    task automatic issue16(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        in_valid16 = 1'b1; a16 = ta; b16 = tb; is_signed16 = ts;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready16 && n < 300);
        if (!in_ready16) begin
            fail_now("accept16");
            in_valid16 = 1'b0;
            return;
        end
        e.prod    = ref_prod(ta, tb, 16, ts);
        e.lat     = ref_lat(tb, 16, ts);
        e.acc_cyc = cyc + 1;
        sb16.push_back(e);
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); is_signed16 = ~ts;
    endtask

    // Walks an accepted operation up to out_valid, requiring in_ready low.
    task automatic watch8();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            chk("in_ready_while_busy8", in_ready8, 0);
            if (out_valid8) break;
            n++;
            if (n > 50) begin
                fail_now("wait_valid8");
                break;
            end
        end
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (sb8.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb8.size() != 0) begin
            fail_now("drain8");
            sb8.delete();
        end
    endtask

    task automatic drain16();
        int n;
        n = 0;
        while (sb16.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb16.size() != 0) begin
            fail_now("drain16");
            sb16.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; is_signed8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; is_signed16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready8", in_ready8, 1);
        chk("reset_out_valid8", out_valid8, 0);
        chk("reset_product8", product8, 0);
        chk("reset_busy8", busy8, 0);
        chk("reset_in_ready16", in_ready16, 1);
        chk("reset_busy16", busy16, 0);
        chk("reset_product16", product16, 0);

        // Unsigned max*max, with in_ready watched through the whole run.
        issue8(8'hFF, 8'hFF, 1'b0, 1'b1);
        watch8();
        drain8();

        // Signed boundaries and mixed-sign cases, then the same bits unsigned.
        issue8(8'h80, 8'h80, 1'b1, 1'b1);
        issue8(8'hFF, 8'h7F, 1'b1, 1'b1);
        issue8(8'h05, 8'hFD, 1'b1, 1'b1);
        issue8(8'h05, 8'hFD, 1'b0, 1'b1);
        issue8(8'h07, 8'h01, 1'b1, 1'b1);
        issue8(8'h07, 8'hFF, 1'b1, 1'b1);
        issue8(8'h80, 8'h7F, 1'b1, 1'b1);
        issue8(8'h00, 8'h00, 1'b0, 1'b1);
        drain8();

        // Backpressure: DONE held, a concurrent in_valid must be ignored.
        @(posedge clk); #1 out_ready8 = 1'b0;
        issue8(8'h12, 8'h34, 1'b1, 1'b1);
        watch8();
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'hBB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_valid8", out_valid8, 1);
            chk("hold_in_ready8", in_ready8, 0);
            chk("hold_busy8", busy8, 1);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        drain8();
        repeat (2) @(negedge clk);
        chk("after_hold_idle8", busy8, 0);

        // Reset in the second CALC cycle discards the operation.
        issue8(8'h55, 8'h66, 1'b1, 1'b0);
        @(negedge clk);
        chk("calc_busy8", busy8, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid8", out_valid8, 0);
        chk("midrst_in_ready8", in_ready8, 1);
        chk("midrst_product8", product8, 0);
        chk("midrst_busy8", busy8, 0);
        issue8(8'h03, 8'h04, 1'b0, 1'b1);
        drain8();

        // Randomised operands with random output backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        drain8();
        bp_en = 1'b0;
        @(posedge clk); #2 out_ready8 = 1'b1;
        drain8();

        // Wider instance: boundaries then a random sweep.
        issue16(16'h8000, 16'h8000, 1'b1);
        issue16(16'hFFFF, 16'hFFFF, 1'b0);
        issue16(16'hFFFF, 16'h0001, 1'b1);
        for (int i = 0; i < 40; i++) begin
            issue16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        drain16();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
